// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   lsu_size_e  : request size encodings (byte/half/word/illegal)
//   lsu_state_e : FSM states of load_store_unit
//   LSU_OFFSET / LSU_DEPTH : default legal word-index window of Data_mem
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10,
        SZ_X = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_WRITE,
        ST_RESP
    } lsu_state_e;

    localparam int unsigned LSU_OFFSET = 256;
    localparam int unsigned LSU_DEPTH  = 1024;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit (little-endian).
//   rdata    in  32  word read from memory
//   wdata    in  32  store data (LSBs used for sub-word stores)
//   size     in  2   lsu_size_e encoding
//   lane     in  2   byte address bits [1:0]
//   sign_ext in  1   1 = sign-extend loads, 0 = zero-extend
//   ext_data out 32  selected lane of rdata, extended to 32 bits
//   merged   out 32  rdata with the selected lane replaced by wdata
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        sign_ext,
    output logic [31:0] ext_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (lane)
            2'd0:    byte_v = rdata[7:0];
            2'd1:    byte_v = rdata[15:8];
            2'd2:    byte_v = rdata[23:16];
            default: byte_v = rdata[31:24];
        endcase
        half_v = lane[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        ext_data = rdata;
        merged   = wdata;
        case (size)
            SZ_B: begin
                ext_data = {{24{sign_ext & byte_v[7]}}, byte_v};
                merged   = rdata;
                case (lane)
                    2'd0:    merged[7:0]   = wdata[7:0];
                    2'd1:    merged[15:8]  = wdata[7:0];
                    2'd2:    merged[23:16] = wdata[7:0];
                    default: merged[31:24] = wdata[7:0];
                endcase
            end
            SZ_H: begin
                ext_data = {{16{sign_ext & half_v[15]}}, half_v};
                merged   = rdata;
                if (lane[1]) merged[31:16] = wdata[15:0];
                else         merged[15:0]  = wdata[15:0];
            end
            default: begin
                ext_data = rdata;
                merged   = wdata;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core memory stage and Data_mem.
// Converts byte-addressed LB/LH/LW/SB/SH/SW into word accesses; sub-word
// stores are read-modify-write. One request outstanding at a time.
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_we/size/signed/addr/wdata  request fields
//   rsp_valid/rsp_ready        response handshake (held until ready)
//   rsp_rdata/rsp_fault        extended load data / fault flag
//   mem_addr/wdata/we/re       Data_mem synchronous port (word index)
//   mem_rdata                  Data_mem read data, valid the cycle after mem_re
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned OFFSET = LSU_OFFSET,
    parameter int unsigned DEPTH  = LSU_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;

    logic        we_q;
    logic [1:0]  size_q;
    logic        sgn_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merged_q;
    logic [31:0] rdata_q;
    logic        fault_q;

    logic [31:0] req_idx;
    logic        in_range;
    logic        misaligned;
    logic        req_fault;
    logic        accept;
    logic        word_store;
    logic [31:0] ext_data;
    logic [31:0] merged;

    // Fault decode on the live request; only used at the accept edge.
    always_comb begin
        req_idx    = {2'b00, req_addr[31:2]};
        in_range   = (req_idx >= OFFSET) && (req_idx <= OFFSET + DEPTH - 1);
        misaligned = ((req_size == SZ_H) && req_addr[0]) ||
                     ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
        req_fault  = (req_size == SZ_X) || misaligned || !in_range;
    end

    assign accept     = req_valid && (state_q == ST_IDLE);
    assign word_store = we_q && (size_q == SZ_W);

    lsu_align u_align (
        .rdata    (mem_rdata),
        .wdata    (wdata_q),
        .size     (size_q),
        .lane     (addr_q[1:0]),
        .sign_ext (sgn_q),
        .ext_data (ext_data),
        .merged   (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // mem_* depend only on state_q and latched fields, never on req_*.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = req_fault ? ST_RESP : ST_ISSUE;
            end
            ST_ISSUE: begin
                if (word_store) begin
                    mem_we    = 1'b1;
                    mem_wdata = wdata_q;
                    state_d   = ST_RESP;
                end else begin
                    mem_re  = 1'b1;
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: state_d = we_q ? ST_WRITE : ST_RESP;
            ST_WRITE: begin
                mem_we    = 1'b1;
                mem_wdata = merged_q;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            size_q   <= SZ_B;
            sgn_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            sgn_q   <= req_signed;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            fault_q <= req_fault;
            rdata_q <= '0;
        end else if (state_q == ST_CAPTURE) begin
            if (we_q) merged_q <= merged;
            else      rdata_q  <= ext_data;
        end
    end

    assign mem_addr  = {2'b00, addr_q[31:2]};
    assign rsp_rdata = rdata_q;
    assign rsp_fault = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int unsigned OFF = 256;
    localparam int unsigned DEP = 1024;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;

    load_store_unit #(.OFFSET(OFF), .DEPTH(DEP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_fault  (rsp_fault),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_re     (mem_re),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data_mem model: synchronous read and write, word-indexed with OFFSET.
    logic [31:0] mem [0:DEP-1];
    logic [31:0] moff;
    assign moff = mem_addr - OFF;
    always @(posedge clk) begin
        if (mem_we && mem_addr >= OFF && mem_addr < OFF + DEP) mem[moff[9:0]] <= mem_wdata;
        if (mem_re && mem_addr >= OFF && mem_addr < OFF + DEP) mem_rdata <= mem[moff[9:0]];
    end

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        fault;
    } rsp_t;
    rsp_t sb[$];
    rsp_t mon_e;

    int          re_cnt = 0;
    int          we_cnt = 0;
    logic [31:0] last_addr = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Monitor: memory activity counters and response scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_re) re_cnt++;
            if (mem_we) we_cnt++;
            if (mem_re || mem_we) last_addr = mem_addr;
            check("re_we_exclusive", 32'(mem_re & mem_we), 32'd0);
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("rsp_rdata", rsp_rdata, mon_e.rdata);
                    check("rsp_fault", 32'(rsp_fault), 32'(mon_e.fault));
                end
            end
        end
    end

    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_fault,
                          input int exp_re, input int exp_we, input bit wait_rsp);
        int re0, we0, n;
        @(posedge clk); #1;
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check({tag, "_accept"}, 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        sb.push_back(rsp_t'{rdata: exp_rdata, fault: exp_fault});
        re0 = re_cnt;
        we0 = we_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!wait_rsp) return;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_done"}, 32'(sb.size() == 0), 32'd1);
        sb.delete();
        check({tag, "_re_cycles"}, 32'(re_cnt - re0), 32'(exp_re));
        check({tag, "_we_cycles"}, 32'(we_cnt - we0), 32'(exp_we));
        if (!exp_fault) check({tag, "_mem_addr"}, last_addr, addr >> 2);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b1;
        #12;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: word store/load
        do_req("sw400", 1, SZ_W, 0, 32'h400, 32'hDEADBEEF, 32'h0,        0, 0, 1, 1);
        do_req("lw400", 0, SZ_W, 0, 32'h400, 32'h0,        32'hDEADBEEF, 0, 1, 0, 1);
        // 2: byte store, byte loads
        do_req("sb401", 1, SZ_B, 0, 32'h401, 32'h55,       32'h0,        0, 1, 1, 1);
        do_req("lw_b",  0, SZ_W, 0, 32'h400, 32'h0,        32'hDEAD55EF, 0, 1, 0, 1);
        do_req("lb403s",0, SZ_B, 1, 32'h403, 32'h0,        32'hFFFFFFDE, 0, 1, 0, 1);
        do_req("lb403u",0, SZ_B, 0, 32'h403, 32'h0,        32'h000000DE, 0, 1, 0, 1);
        // 3: half store, half loads
        do_req("sh402", 1, SZ_H, 0, 32'h402, 32'h1234,     32'h0,        0, 1, 1, 1);
        do_req("lh402s",0, SZ_H, 1, 32'h402, 32'h0,        32'h00001234, 0, 1, 0, 1);
        do_req("lw_h",  0, SZ_W, 0, 32'h400, 32'h0,        32'h123455EF, 0, 1, 0, 1);
        do_req("sh400", 1, SZ_H, 0, 32'h400, 32'hFFFF8001, 32'h0,        0, 1, 1, 1);
        do_req("lh400s",0, SZ_H, 1, 32'h400, 32'h0,        32'hFFFF8001, 0, 1, 0, 1);
        do_req("lh400u",0, SZ_H, 0, 32'h400, 32'h0,        32'h00008001, 0, 1, 0, 1);
        do_req("lb401s",0, SZ_B, 1, 32'h401, 32'h0,        32'hFFFFFF80, 0, 1, 0, 1);
        do_req("lb400s",0, SZ_B, 1, 32'h400, 32'h0,        32'h00000001, 0, 1, 0, 1);
        // 4: faults and range boundaries
        do_req("f_mis",  0, SZ_W, 0, 32'h402,  32'h0, 32'h0, 1, 0, 0, 1);
        do_req("f_low",  0, SZ_W, 0, 32'h3FC,  32'h0, 32'h0, 1, 0, 0, 1);
        do_req("f_high", 0, SZ_W, 0, 32'h1400, 32'h0, 32'h0, 1, 0, 0, 1);
        do_req("f_size", 0, SZ_X, 0, 32'h400,  32'h0, 32'h0, 1, 0, 0, 1);
        do_req("f_lh",   0, SZ_H, 0, 32'h401,  32'h0, 32'h0, 1, 0, 0, 1);
        do_req("f_sw",   1, SZ_W, 0, 32'h1400, 32'h1, 32'h0, 1, 0, 0, 1);
        do_req("sw_top", 1, SZ_W, 0, 32'h13FC, 32'hA5A5A5A5, 32'h0,        0, 0, 1, 1);
        do_req("lw_top", 0, SZ_W, 0, 32'h13FC, 32'h0,        32'hA5A5A5A5, 0, 1, 0, 1);
        do_req("lw_bot", 0, SZ_W, 0, 32'h400,  32'h0,        32'h12348001, 0, 1, 0, 1);

        // 5: response back-pressure
        rsp_ready = 1'b0;
        do_req("lw_hold", 0, SZ_W, 0, 32'h400, 32'h0, 32'h12348001, 0, 1, 0, 0);
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold_rsp_arrive", 32'(rsp_valid), 32'd1);
        repeat (5) begin
            @(posedge clk); #1;
            req_we    = 1'b0;
            req_size  = SZ_W;
            req_addr  = 32'h404;
            req_valid = 1'b1;
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_rsp_rdata", rsp_rdata, 32'h12348001);
            check("hold_rsp_fault", 32'(rsp_fault), 32'd0);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_mem_idle", 32'(mem_re | mem_we), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        check("release_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("release_popped", 32'(sb.size()), 32'd0);
        sb.delete();
        @(negedge clk);
        check("after_req_ready", 32'(req_ready), 32'd1);

        // 6: reset during the WRITE phase of an SB
        do_req("sw404", 1, SZ_W, 0, 32'h404, 32'hCAFEF00D, 32'h0, 0, 0, 1, 1);
        @(posedge clk); #1;
        req_we    = 1'b1;
        req_size  = SZ_B;
        req_signed= 1'b0;
        req_addr  = 32'h404;
        req_wdata = 32'h77;
        req_valid = 1'b1;
        @(negedge clk);
        check("t6_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("t6_in_write", 32'(mem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_we_dropped", 32'(mem_we), 32'd0);
        check("t6_req_ready", 32'(req_ready), 32'd1);
        check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("t6_word_kept", mem[1], 32'hCAFEF00D);
        @(negedge clk);
        rst_n = 1'b1;
        do_req("lw404", 0, SZ_W, 0, 32'h404, 32'h0, 32'hCAFEF00D, 0, 1, 0, 1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
